axis_pattern_gen: RTL
=====================

AXIS_PATTERN_GEN -- requirements
Module: axis_pattern_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 The block SHALL have parameter FRAME_WIDTH, default 640: pixels per line.
REQ-003 The block SHALL have parameter FRAME_HEIGHT, default 512: lines per frame.
REQ-004 The block SHALL have parameter LINE_GAP, default 0: idle cycles (tvalid=0) after every tlast beat.
REQ-005 The block SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1: single-cycle pulse, begins a run when idle.
REQ-008 The block SHALL have port stop, input, 1: single-cycle pulse, ends the run at the next frame boundary.
REQ-009 The block SHALL have port mode, input, 2: pattern select, sampled at each frame start.
REQ-010 The block SHALL have port num_frames, input, 16: frames per run, sampled on start; 0 = continuous.
REQ-011 The block SHALL have ports m_axis_tdata (DATA_WIDTH), m_axis_tvalid, m_axis_tlast and m_axis_tuser as outputs, with m_axis_tready (1) as an input: the AXI4-Stream video master.
REQ-012 The block SHALL have port busy, output, 1: high from start acceptance until the run ends.
REQ-013 The block SHALL have port frame_done, output, 1: one-cycle pulse on the handshake of the last beat of each frame.
REQ-014 The block SHALL have port frames_sent, output, 16: frames completed in the current run, wrapping at 2^16.

Function
REQ-015 The FSM SHALL have states IDLE, ACTIVE and GAP.
REQ-016 In IDLE, start SHALL move the FSM to ACTIVE on the next edge, clear frames_sent, latch num_frames, and set row=col=0; start in ACTIVE or GAP SHALL be ignored.
REQ-017 In ACTIVE, m_axis_tvalid SHALL be 1, and a beat SHALL transfer only when tvalid and tready are both high.
REQ-018 While tvalid=1 and tready=0, tdata, tlast and tuser SHALL be held stable.
REQ-019 m_axis_tuser SHALL be 1 only at row=0, col=0; m_axis_tlast SHALL be 1 only at col=FRAME_WIDTH-1.
REQ-020 On each handshake, col SHALL increment; at col=FRAME_WIDTH-1, col SHALL wrap to 0 and row SHALL increment; at row=FRAME_HEIGHT-1, row SHALL wrap to 0.
REQ-021 After a tlast handshake, the FSM SHALL enter GAP for exactly LINE_GAP cycles with tvalid=0 when LINE_GAP>0, and SHALL otherwise stay in ACTIVE with no bubble.
REQ-022 On the handshake of the last frame beat, frames_sent SHALL increment and frame_done SHALL pulse in the following cycle.
REQ-023 If frames_sent reaches the latched num_frames (when nonzero), or a stop is pending, the FSM SHALL go to IDLE after the last beat with no trailing gap, and busy SHALL fall in the same cycle that tvalid falls.
REQ-024 A stop pulse SHALL be latched as pending, SHALL never truncate a frame, and SHALL be cleared on entry to IDLE.
REQ-025 Mode 0 SHALL output tdata = (row+col) mod 2^DATA_WIDTH.
REQ-026 Mode 1 SHALL output tdata = col mod 2^DATA_WIDTH.
REQ-027 Mode 2 SHALL output an 8x8 checkerboard: all ones if (row[3]^col[3]) is 1, else 0.
REQ-028 Mode 3 SHALL be as defined under Configuration.
REQ-029 tdata SHALL come from registers, with no combinational path from tready to any output other than through the state registers.

Reset
REQ-030 Asserting rst_n low SHALL immediately force IDLE, with tvalid, tlast, tuser, busy and frame_done at 0, tdata=0, frames_sent=0, row=col=0, and stop pending cleared.
REQ-031 Reset mid-frame SHALL abandon the frame, and the next start SHALL begin at tuser.

Configuration
REQ-032 Macro PATGEN_LFSR_EN defined SHALL make mode 3 a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 at each frame start and advanced per handshake, with tdata = the LFSR's low DATA_WIDTH bits.
REQ-033 Macro PATGEN_LFSR_EN undefined SHALL make mode 3 output the constant 2^(DATA_WIDTH-1), and no LFSR logic SHALL be present.

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=3, DATA_WIDTH=8 unless stated)
REQ-034 Bench SHALL drive start, mode=0, num_frames=1, tready=1 -> 12 beats, tdata 0,1,2,3,1,2,3,4,2,3,4,5, tuser on beat 1 only, tlast on beats 4/8/12, frame_done once, frames_sent=1, then busy=0.
REQ-035 Bench SHALL toggle tready randomly at 50% -> same 12-beat sequence, with outputs stable during every stall.
REQ-036 Bench SHALL set LINE_GAP=2, mode=1, num_frames=2 -> tvalid low exactly 2 cycles after each tlast except the final one, with 24 beats of tdata 0..3 repeating and frames_sent=2.
REQ-037 Bench SHALL drive num_frames=0 with stop pulsed at beat 5 of frame 2 -> frame 2 completes all 12 beats, then IDLE, frames_sent=2.
REQ-038 Bench SHALL pulse rst_n low at beat 7 -> outputs zero asynchronously; a subsequent start begins with tuser=1, tdata=0.
REQ-039 Bench SHALL select mode 3 -> with PATGEN_LFSR_EN the first beat is 8'hE1; without it, every beat is 8'h80.

Source files
------------

// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: AXI4-Stream video test-pattern master (FRAME_WIDTH x FRAME_HEIGHT frames).
// Latency: first beat valid the cycle after start is accepted; tdata is registered one beat ahead.
// Backpressure: beats advance only on tvalid&tready; data/last/user hold while tready is low.
//
// Ports:
//   clk, rst_n              - single rising-edge clock, asynchronous active-low reset
//   start, stop             - run control pulses (stop takes effect at the next frame boundary)
//   mode, num_frames        - pattern select (per frame), frames per run (0 = continuous)
//   m_axis_*                - AXI4-Stream master; tuser marks first pixel, tlast marks line end
//   busy, frame_done,
//   frames_sent             - run status
//
// Optional feature: define PATGEN_LFSR_EN to make mode 3 a 16-bit Fibonacci LFSR
// (taps 16,14,13,11, reseeded to 16'hACE1 at each frame start). Without it, mode 3 is a
// constant mid-scale value and no LFSR state exists.
module axis_pattern_gen #(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 512,
  parameter int LINE_GAP     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [15:0]           num_frames,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frames_sent
);

  localparam int CW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
  // Gap counter counts 0..LINE_GAP-1 while in GAP.
  localparam logic [15:0]   GAP_LAST = (LINE_GAP > 0) ? 16'(LINE_GAP - 1) : 16'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [15:0]           frames_sent_q, frames_sent_d;
  logic [15:0]           num_frames_q, num_frames_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [1:0]            mode_q, mode_d;
  logic [15:0]           gap_cnt_q, gap_cnt_d;
`ifdef PATGEN_LFSR_EN
  logic [15:0]           lfsr_q, lfsr_d;
`endif

  logic        line_end;
  logic        frame_end;
  logic        load;
  logic        new_frame;
  logic        checker_on;
  logic [15:0] frames_inc;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    frames_sent_d = frames_sent_q;
    num_frames_d  = num_frames_q;
    stop_pend_d   = stop_pend_q;
    frame_done_d  = 1'b0;
    tdata_d       = tdata_q;
    mode_d        = mode_q;
    gap_cnt_d     = gap_cnt_q;
`ifdef PATGEN_LFSR_EN
    lfsr_d        = lfsr_q;
`endif
    load          = 1'b0;

    line_end   = (col_q == COL_LAST);
    frame_end  = line_end && (row_q == ROW_LAST);
    frames_inc = frames_sent_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = ACTIVE;
          frames_sent_d = 16'd0;
          num_frames_d  = num_frames;
          row_d         = '0;
          col_d         = '0;
          stop_pend_d   = 1'b0;
          load          = 1'b1;
        end
      end
      ACTIVE: begin
        if (stop) stop_pend_d = 1'b1;
        if (m_axis_tready) begin
          load = 1'b1;
          if (line_end) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (frame_end) begin
            frames_sent_d = frames_inc;
            frame_done_d  = 1'b1;
          end
          // A finishing frame goes straight to IDLE: no trailing gap, so busy
          // and tvalid drop together. A stop arriving on this very beat counts.
          if (frame_end && (((num_frames_q != 16'd0) && (frames_inc == num_frames_q)) ||
                            stop_pend_q || stop)) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end else if (line_end && (LINE_GAP > 0)) begin
            state_d   = GAP;
            gap_cnt_d = 16'd0;
          end
        end
      end
      GAP: begin
        if (stop) stop_pend_d = 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ACTIVE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tdata is precomputed for the beat about to be presented. The pattern mode
    // (and the LFSR seed) is captured when that beat is the first pixel of a frame.
    new_frame  = (row_d == '0) && (col_d == '0);
    checker_on = (((32'(row_d) ^ 32'(col_d)) >> 3) & 32'd1) != 32'd0;
    if (load) begin
      if (new_frame) mode_d = mode;
`ifdef PATGEN_LFSR_EN
      if (new_frame) lfsr_d = 16'hACE1;
      else           lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
      case (mode_d)
        2'd0:    tdata_d = DATA_WIDTH'(32'(row_d) + 32'(col_d));
        2'd1:    tdata_d = DATA_WIDTH'(col_d);
        2'd2:    tdata_d = {DATA_WIDTH{checker_on}};
`ifdef PATGEN_LFSR_EN
        default: tdata_d = DATA_WIDTH'(lfsr_d);
`else
        default: tdata_d = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
`endif
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      frames_sent_q <= 16'd0;
      num_frames_q  <= 16'd0;
      stop_pend_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      tdata_q       <= '0;
      mode_q        <= 2'd0;
      gap_cnt_q     <= 16'd0;
`ifdef PATGEN_LFSR_EN
      lfsr_q        <= 16'hACE1;
`endif
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frames_sent_q <= frames_sent_d;
      num_frames_q  <= num_frames_d;
      stop_pend_q   <= stop_pend_d;
      frame_done_q  <= frame_done_d;
      tdata_q       <= tdata_d;
      mode_q        <= mode_d;
      gap_cnt_q     <= gap_cnt_d;
`ifdef PATGEN_LFSR_EN
      lfsr_q        <= lfsr_d;
`endif
    end
  end

  // All outputs decode registered state only; tready never reaches them combinationally.
  assign m_axis_tvalid = (state_q == ACTIVE);
  assign m_axis_tlast  = m_axis_tvalid && (col_q == COL_LAST);
  assign m_axis_tuser  = m_axis_tvalid && (row_q == '0) && (col_q == '0);
  assign m_axis_tdata  = tdata_q;
  assign busy          = (state_q != IDLE);
  assign frame_done    = frame_done_q;
  assign frames_sent   = frames_sent_q;

endmodule
